// File: rtl/lcd_line_composer.sv
// Two-line, 16-column LCD text composer for clock/alarm/timer status.
// Inputs are snapshotted periodically; both lines are rebuilt from the snapshot one cycle later.
module lcd_line_composer #(
    parameter int MFREQ_KHZ = 1,
    parameter int SNAP_MS   = 100,
    parameter int BLINK_MS  = 500
) (
    input  logic         mclk,
    input  logic         rst_n,
    input  logic [7:0]   hr_bcd,
    input  logic [7:0]   min_bcd,
    input  logic [7:0]   sec_bcd,
    input  logic [7:0]   alarm_hr,
    input  logic [7:0]   alarm_min,
    input  logic         alarm_en,
    input  logic [7:0]   timer_min,
    input  logic [7:0]   timer_sec,
    input  logic         timer_run,
    input  logic [1:0]   mode,
    input  logic [1:0]   edit_field,
    output logic [127:0] LineA,
    output logic [127:0] LineB,
    output logic         frame_upd,
    output logic         bcd_err
);

    localparam int MS_W    = (MFREQ_KHZ > 1) ? $clog2(MFREQ_KHZ) : 1;
    localparam int SNAP_W  = (SNAP_MS > 1)   ? $clog2(SNAP_MS)   : 1;
    localparam int BLINK_W = (BLINK_MS > 1)  ? $clog2(BLINK_MS)  : 1;
    localparam logic [MS_W-1:0]    MS_LAST    = MS_W'(MFREQ_KHZ - 1);
    localparam logic [SNAP_W-1:0]  SNAP_LAST  = SNAP_W'(SNAP_MS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_MS - 1);

    localparam logic [1:0] MODE_ALARM = 2'd1;
    localparam logic [1:0] MODE_TIMER = 2'd2;

    logic [MS_W-1:0]    ms_cnt_q;
    logic [SNAP_W-1:0]  snap_cnt_q;
    logic [BLINK_W-1:0] blink_cnt_q;
    logic               blink_phase_q;
    logic               compose_q;

    logic [7:0] sh_hr_q, sh_min_q, sh_sec_q, sh_ahr_q, sh_amin_q, sh_tmin_q, sh_tsec_q;
    logic       sh_aen_q, sh_trun_q;
    logic [1:0] sh_mode_q, sh_field_q;

    logic [127:0] line_a_q, line_b_q, line_a_d, line_b_d;
    logic         frame_upd_q, bcd_err_q, bcd_err_d;

    logic ms_tick, snap_wrap, blink_wrap, snap_ev;
    logic [7:0] a_col [16];
    logic [7:0] b_col [16];

    assign ms_tick    = (ms_cnt_q == MS_LAST);
    assign snap_wrap  = ms_tick && (snap_cnt_q == SNAP_LAST);
    assign blink_wrap = ms_tick && (blink_cnt_q == BLINK_LAST);
    assign snap_ev    = snap_wrap || blink_wrap;

    function automatic logic [7:0] dig(input logic [3:0] n);
        return (n > 4'd9) ? 8'h3F : {4'h3, n};
    endfunction

    function automatic logic bad(input logic [7:0] b);
        return (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
    endfunction

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            a_col[i] = 8'h20;
            b_col[i] = 8'h20;
        end
        bcd_err_d = bad(sh_ahr_q) || bad(sh_amin_q);
        case (sh_mode_q)
            MODE_ALARM: begin
                a_col[0] = "A"; a_col[1] = "L"; a_col[2] = "R"; a_col[3] = "M";
                a_col[6] = dig(sh_ahr_q[7:4]);  a_col[7]  = dig(sh_ahr_q[3:0]);
                a_col[8] = ":";
                a_col[9] = dig(sh_amin_q[7:4]); a_col[10] = dig(sh_amin_q[3:0]);
            end
            MODE_TIMER: begin
                a_col[0] = "T"; a_col[1] = "I"; a_col[2] = "M"; a_col[3] = "R";
                a_col[9]  = dig(sh_tmin_q[7:4]); a_col[10] = dig(sh_tmin_q[3:0]);
                a_col[11] = ":";
                a_col[12] = dig(sh_tsec_q[7:4]); a_col[13] = dig(sh_tsec_q[3:0]);
                a_col[15] = sh_trun_q ? 8'h01 : 8'h20;
                bcd_err_d = bcd_err_d || bad(sh_tmin_q) || bad(sh_tsec_q);
            end
            default: begin
                a_col[0] = "T"; a_col[1] = "I"; a_col[2] = "M"; a_col[3] = "E";
                a_col[6]  = dig(sh_hr_q[7:4]);  a_col[7]  = dig(sh_hr_q[3:0]);
                a_col[8]  = ":";
                a_col[9]  = dig(sh_min_q[7:4]); a_col[10] = dig(sh_min_q[3:0]);
                a_col[11] = ":";
                a_col[12] = dig(sh_sec_q[7:4]); a_col[13] = dig(sh_sec_q[3:0]);
                a_col[15] = sh_aen_q ? 8'h00 : 8'h20;
                bcd_err_d = bcd_err_d || bad(sh_hr_q) || bad(sh_min_q) || bad(sh_sec_q);
            end
        endcase
        // Blanking only overwrites with spaces, so fields absent in a mode stay untouched.
        if (blink_phase_q) begin
            case (sh_field_q)
                2'd1:    begin a_col[6]  = 8'h20; a_col[7]  = 8'h20; end
                2'd2:    begin a_col[9]  = 8'h20; a_col[10] = 8'h20; end
                2'd3:    begin a_col[12] = 8'h20; a_col[13] = 8'h20; end
                default: ;
            endcase
        end
        b_col[0] = "A"; b_col[1] = "L"; b_col[2] = "A"; b_col[3] = "R"; b_col[4] = "M";
        b_col[6]  = dig(sh_ahr_q[7:4]);  b_col[7]  = dig(sh_ahr_q[3:0]);
        b_col[8]  = ":";
        b_col[9]  = dig(sh_amin_q[7:4]); b_col[10] = dig(sh_amin_q[3:0]);
        b_col[12] = sh_aen_q ? 8'h20 : "O";
        b_col[13] = sh_aen_q ? "O"   : "F";
        b_col[14] = sh_aen_q ? "N"   : "F";
    end

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_pack
            assign line_a_d[8*gi +: 8] = a_col[gi];
            assign line_b_d[8*gi +: 8] = b_col[gi];
        end
    endgenerate

    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            ms_cnt_q      <= '0;
            snap_cnt_q    <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            compose_q     <= 1'b0;
            sh_hr_q <= '0; sh_min_q <= '0; sh_sec_q <= '0;
            sh_ahr_q <= '0; sh_amin_q <= '0; sh_aen_q <= 1'b0;
            sh_tmin_q <= '0; sh_tsec_q <= '0; sh_trun_q <= 1'b0;
            sh_mode_q <= '0; sh_field_q <= '0;
            line_a_q    <= {16{8'h20}};
            line_b_q    <= {16{8'h20}};
            frame_upd_q <= 1'b0;
            bcd_err_q   <= 1'b0;
        end else begin
            ms_cnt_q <= ms_tick ? '0 : ms_cnt_q + 1'b1;
            if (ms_tick) begin
                snap_cnt_q  <= snap_wrap  ? '0 : snap_cnt_q + 1'b1;
                blink_cnt_q <= blink_wrap ? '0 : blink_cnt_q + 1'b1;
            end
            if (blink_wrap) begin
                blink_phase_q <= ~blink_phase_q;
            end
            if (snap_ev) begin
                sh_hr_q <= hr_bcd; sh_min_q <= min_bcd; sh_sec_q <= sec_bcd;
                sh_ahr_q <= alarm_hr; sh_amin_q <= alarm_min; sh_aen_q <= alarm_en;
                sh_tmin_q <= timer_min; sh_tsec_q <= timer_sec; sh_trun_q <= timer_run;
                sh_mode_q <= mode; sh_field_q <= edit_field;
            end
            compose_q   <= snap_ev;
            frame_upd_q <= 1'b0;
            if (compose_q) begin
                line_a_q    <= line_a_d;
                line_b_q    <= line_b_d;
                frame_upd_q <= (line_a_d != line_a_q) || (line_b_d != line_b_q);
                bcd_err_q   <= bcd_err_d;
            end
        end
    end

    assign LineA     = line_a_q;
    assign LineB     = line_b_q;
    assign frame_upd = frame_upd_q;
    assign bcd_err   = bcd_err_q;

endmodule

// File: tb/tb_lcd_line_composer.sv
// Directed bench for lcd_line_composer with 1 kHz clock, 4 ms snapshots, 8 ms blink.
// n_edges counts rising edges since reset release; lines refresh when n_edges = 5, 9, 13, ...
module tb_lcd_line_composer;

    logic         mclk = 1'b0;
    logic         rst_n;
    logic [7:0]   hr_bcd, min_bcd, sec_bcd, alarm_hr, alarm_min, timer_min, timer_sec;
    logic         alarm_en, timer_run;
    logic [1:0]   mode, edit_field;
    logic [127:0] LineA, LineB;
    logic         frame_upd, bcd_err;

    int tests = 0;
    int fails = 0;
    int n_edges = 0;

    lcd_line_composer #(.MFREQ_KHZ(1), .SNAP_MS(4), .BLINK_MS(8)) dut (
        .mclk(mclk), .rst_n(rst_n),
        .hr_bcd(hr_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
        .alarm_hr(alarm_hr), .alarm_min(alarm_min), .alarm_en(alarm_en),
        .timer_min(timer_min), .timer_sec(timer_sec), .timer_run(timer_run),
        .mode(mode), .edit_field(edit_field),
        .LineA(LineA), .LineB(LineB), .frame_upd(frame_upd), .bcd_err(bcd_err)
    );

    always #5 mclk = ~mclk;

    always @(posedge mclk) begin
        if (!rst_n) n_edges <= 0;
        else        n_edges <= n_edges + 1;
    end

    // Turns a left-to-right string literal into the column-0-at-LSB layout.
    function automatic logic [127:0] cols(input logic [127:0] s);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = s[8*(15-k) +: 8];
        return r;
    endfunction

    localparam logic [127:0] SPACES = {16{8'h20}};
    localparam logic [127:0] S_CLK56  = {"TIME  12:34:56 ", 8'h00};
    localparam logic [127:0] S_CLK57  = {"TIME  12:34:57 ", 8'h00};
    localparam logic [127:0] S_BLANK  = {"TIME  12:  :57 ", 8'h00};
    localparam logic [127:0] S_BADMIN = {"TIME  12:3?:57 ", 8'h00};
    localparam logic [127:0] S_TIMR   = {"TIMR     05:09 ", 8'h01};
    localparam logic [127:0] S_CLKOFF = "TIME  12:34:57  ";
    localparam logic [127:0] S_ALRM   = "ALRM  23:59     ";
    localparam logic [127:0] S_B_ON   = "ALARM 07:30  ON ";
    localparam logic [127:0] S_B_OFF  = "ALARM 07:30 OFF ";
    localparam logic [127:0] S_B_23   = "ALARM 23:59 OFF ";

    task automatic step(input int k);
        for (int i = 0; i < k; i++) @(negedge mclk);
    endtask

    task automatic to_update();
        for (int i = 0; i < 8; i++) begin
            @(negedge mclk);
            if (n_edges >= 5 && (n_edges % 4) == 1) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        hr_bcd = 8'h12; min_bcd = 8'h34; sec_bcd = 8'h56;
        alarm_hr = 8'h07; alarm_min = 8'h30; alarm_en = 1'b1;
        timer_min = 8'h00; timer_sec = 8'h00; timer_run = 1'b0;
        mode = 2'd0; edit_field = 2'd0;
        step(3);
        tests++; if (LineA !== SPACES) begin fails++; $display("FAIL reset_lineA got=%h exp=%h", LineA, SPACES); end
        tests++; if (LineB !== SPACES) begin fails++; $display("FAIL reset_lineB got=%h exp=%h", LineB, SPACES); end
        tests++; if (frame_upd !== 1'b0) begin fails++; $display("FAIL reset_frame_upd got=%b exp=0", frame_upd); end
        tests++; if (bcd_err !== 1'b0) begin fails++; $display("FAIL reset_bcd_err got=%b exp=0", bcd_err); end
        rst_n = 1'b1;
        step(4);
        tests++; if (LineA !== SPACES) begin fails++; $display("FAIL early_update got=%h exp=%h", LineA, SPACES); end
        tests++; if (frame_upd !== 1'b0) begin fails++; $display("FAIL early_frame_upd got=%b exp=0", frame_upd); end
        $display("[TB] test_reset done at n_edges=%0d", n_edges);
    endtask

    task automatic test_clock_mode();
        step(1);
        tests++; if (LineA !== cols(S_CLK56)) begin fails++; $display("FAIL clock_lineA got=%h exp=%h", LineA, cols(S_CLK56)); end
        tests++; if (LineB !== cols(S_B_ON)) begin fails++; $display("FAIL clock_lineB got=%h exp=%h", LineB, cols(S_B_ON)); end
        tests++; if (frame_upd !== 1'b1) begin fails++; $display("FAIL clock_frame_upd got=%b exp=1", frame_upd); end
        step(1);
        tests++; if (frame_upd !== 1'b0) begin fails++; $display("FAIL clock_pulse_width got=%b exp=0", frame_upd); end
        $display("[TB] test_clock_mode done at n_edges=%0d", n_edges);
    endtask

    task automatic test_stable();
        to_update();
        tests++; if (frame_upd !== 1'b0) begin fails++; $display("FAIL stable_frame_upd got=%b exp=0", frame_upd); end
        tests++; if (LineA !== cols(S_CLK56)) begin fails++; $display("FAIL stable_lineA got=%h exp=%h", LineA, cols(S_CLK56)); end
        $display("[TB] test_stable done at n_edges=%0d", n_edges);
    endtask

    task automatic test_sec_change();
        step(1);
        sec_bcd = 8'h57;
        step(2);
        tests++; if (LineA[13*8 +: 8] !== 8'h36) begin fails++; $display("FAIL sec_before_snap got=%h exp=36", LineA[13*8 +: 8]); end
        step(1);
        tests++; if (LineA !== cols(S_CLK57)) begin fails++; $display("FAIL sec_after_snap got=%h exp=%h", LineA, cols(S_CLK57)); end
        tests++; if (frame_upd !== 1'b1) begin fails++; $display("FAIL sec_frame_upd got=%b exp=1", frame_upd); end
        step(1);
        $display("[TB] test_sec_change done at n_edges=%0d", n_edges);
    endtask

    task automatic test_blink();
        edit_field = 2'd2;
        to_update();
        tests++; if (LineA !== cols(S_CLK57)) begin fails++; $display("FAIL blink_off1 got=%h exp=%h", LineA, cols(S_CLK57)); end
        tests++; if (frame_upd !== 1'b0) begin fails++; $display("FAIL blink_off1_upd got=%b exp=0", frame_upd); end
        to_update();
        to_update();
        tests++; if (LineA !== cols(S_BLANK)) begin fails++; $display("FAIL blink_on got=%h exp=%h", LineA, cols(S_BLANK)); end
        tests++; if (frame_upd !== 1'b1) begin fails++; $display("FAIL blink_on_upd got=%b exp=1", frame_upd); end
        step(1);
        tests++; if (frame_upd !== 1'b0) begin fails++; $display("FAIL blink_single_pulse got=%b exp=0", frame_upd); end
        to_update();
        tests++; if (frame_upd !== 1'b0) begin fails++; $display("FAIL blink_hold_upd got=%b exp=0", frame_upd); end
        to_update();
        tests++; if (LineA !== cols(S_CLK57)) begin fails++; $display("FAIL blink_off2 got=%h exp=%h", LineA, cols(S_CLK57)); end
        tests++; if (frame_upd !== 1'b1) begin fails++; $display("FAIL blink_off2_upd got=%b exp=1", frame_upd); end
        $display("[TB] test_blink done at n_edges=%0d", n_edges);
    endtask

    task automatic test_invalid_bcd();
        edit_field = 2'd0;
        min_bcd = 8'h3C;
        to_update();
        tests++; if (LineA !== cols(S_BADMIN)) begin fails++; $display("FAIL badbcd_lineA got=%h exp=%h", LineA, cols(S_BADMIN)); end
        tests++; if (bcd_err !== 1'b1) begin fails++; $display("FAIL badbcd_err got=%b exp=1", bcd_err); end
        min_bcd = 8'h34;
        to_update();
        tests++; if (bcd_err !== 1'b0) begin fails++; $display("FAIL badbcd_clear got=%b exp=0", bcd_err); end
        tests++; if (LineA !== cols(S_CLK57)) begin fails++; $display("FAIL badbcd_restore got=%h exp=%h", LineA, cols(S_CLK57)); end
        $display("[TB] test_invalid_bcd done at n_edges=%0d", n_edges);
    endtask

    task automatic test_timer_mode();
        mode = 2'd2; timer_min = 8'h05; timer_sec = 8'h09; timer_run = 1'b1;
        edit_field = 2'd1; hr_bcd = 8'hAA;
        to_update();
        tests++; if (LineA !== cols(S_TIMR)) begin fails++; $display("FAIL timer_lineA got=%h exp=%h", LineA, cols(S_TIMR)); end
        tests++; if (LineB !== cols(S_B_ON)) begin fails++; $display("FAIL timer_lineB got=%h exp=%h", LineB, cols(S_B_ON)); end
        tests++; if (bcd_err !== 1'b0) begin fails++; $display("FAIL timer_unused_bcd got=%b exp=0", bcd_err); end
        to_update();
        tests++; if (LineA !== cols(S_TIMR)) begin fails++; $display("FAIL timer_blink_noop got=%h exp=%h", LineA, cols(S_TIMR)); end
        tests++; if (frame_upd !== 1'b0) begin fails++; $display("FAIL timer_blink_upd got=%b exp=0", frame_upd); end
        $display("[TB] test_timer_mode done at n_edges=%0d", n_edges);
    endtask

    task automatic test_mode3();
        mode = 2'd3; edit_field = 2'd0; hr_bcd = 8'h12; alarm_en = 1'b0;
        to_update();
        tests++; if (LineA !== cols(S_CLKOFF)) begin fails++; $display("FAIL mode3_lineA got=%h exp=%h", LineA, cols(S_CLKOFF)); end
        tests++; if (LineB !== cols(S_B_OFF)) begin fails++; $display("FAIL mode3_lineB got=%h exp=%h", LineB, cols(S_B_OFF)); end
        $display("[TB] test_mode3 done at n_edges=%0d", n_edges);
    endtask

    task automatic test_alarm_mode();
        mode = 2'd1; alarm_hr = 8'h23; alarm_min = 8'h59; edit_field = 2'd3;
        to_update();
        tests++; if (LineA !== cols(S_ALRM)) begin fails++; $display("FAIL alarm_lineA got=%h exp=%h", LineA, cols(S_ALRM)); end
        tests++; if (LineB !== cols(S_B_23)) begin fails++; $display("FAIL alarm_lineB got=%h exp=%h", LineB, cols(S_B_23)); end
        $display("[TB] test_alarm_mode done at n_edges=%0d", n_edges);
    endtask

    task automatic test_reset_mid();
        step(2);
        rst_n = 1'b0;
        step(1);
        tests++; if (LineA !== SPACES) begin fails++; $display("FAIL midrst_lineA got=%h exp=%h", LineA, SPACES); end
        tests++; if (LineB !== SPACES) begin fails++; $display("FAIL midrst_lineB got=%h exp=%h", LineB, SPACES); end
        rst_n = 1'b1;
        step(4);
        tests++; if (LineA !== SPACES) begin fails++; $display("FAIL midrst_aborted_snap got=%h exp=%h", LineA, SPACES); end
        step(1);
        tests++; if (LineA !== cols(S_ALRM)) begin fails++; $display("FAIL midrst_first_update got=%h exp=%h", LineA, cols(S_ALRM)); end
        tests++; if (frame_upd !== 1'b1) begin fails++; $display("FAIL midrst_frame_upd got=%b exp=1", frame_upd); end
        $display("[TB] test_reset_mid done at n_edges=%0d", n_edges);
    endtask

    initial begin
        test_reset();
        test_clock_mode();
        test_stable();
        test_sec_change();
        test_blink();
        test_invalid_bcd();
        test_timer_mode();
        test_mode3();
        test_alarm_mode();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
